rect_painter: RTL
=================

RECT_PAINTER -- requirements
Module: rect_painter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 160, giving the pixels per row of the frame.
REQ-002 The block SHALL have parameter HEIGHT, default 120, giving the rows per frame.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port cmdValid, input, 1 bit: a command is offered this cycle.
REQ-006 The block SHALL have port cmdReady, output, 1 bit: the block accepts a command this cycle.
REQ-007 The block SHALL have port cmdOp, input, 2 bits: 0 FILL, 1 CLEAR, 2 SWAP, 3 NOP.
REQ-008 The block SHALL have ports cmdX0 and cmdX1, input, 8 bits each: inclusive rectangle column bounds.
REQ-009 The block SHALL have ports cmdY0 and cmdY1, input, 7 bits each: inclusive rectangle row bounds.
REQ-010 The block SHALL have port cmdColor, input, 3 bits: {R,G,B} fill colour.
REQ-011 The block SHALL have port vblank, input, 1 bit: level, high during vertical blanking.
REQ-012 The block SHALL have port we, output, 1 bit: frame-buffer pixel write enable.
REQ-013 The block SHALL have port wrtPtr, output, 15 bits: pixel address y*WIDTH+x.
REQ-014 The block SHALL have port dataIn, output, 3 bits: pixel colour to write.
REQ-015 The block SHALL have port swapBuffers, output, 1 bit: one-cycle front/back swap pulse.
REQ-016 The block SHALL have port busy, output, 1 bit: equal to ~cmdReady.

Function
REQ-017 The FSM SHALL have states IDLE, FILL and WAITVBL; cmdReady SHALL be 1 only in IDLE.
REQ-018 A command SHALL be accepted on a clk edge with cmdValid&&cmdReady; it SHALL be ignored otherwise.
REQ-019 On acceptance, FILL SHALL clamp X1 to min(cmdX1,WIDTH-1) and Y1 to min(cmdY1,HEIGHT-1); CLEAR SHALL use 0..WIDTH-1 by 0..HEIGHT-1.
REQ-020 If cmdX0>X1 or cmdY0>Y1 after clamping, the command SHALL be consumed with no writes, and the block SHALL stay in IDLE.
REQ-021 Otherwise the block SHALL enter FILL with we=1, wrtPtr=Y0*WIDTH+X0 and dataIn=cmdColor in the first cycle after acceptance (latency 1).
REQ-022 In FILL, exactly one pixel SHALL be written per cycle in raster order: x increments; at x==X1, x returns to X0 and y increments.
REQ-023 wrtPtr SHALL be formed as rowBase+x, with rowBase advanced by WIDTH per row; no multiplier SHALL be used after the initial shift-add.
REQ-024 The cycle after the pixel (X1,Y1) is written, the block SHALL be in IDLE with we=0, giving exactly (X1-X0+1)*(Y1-Y0+1) cycles with we=1.
REQ-025 SWAP SHALL enter WAITVBL; on the first vblank rising edge (vblank high, previous-cycle registered vblank low) swapBuffers SHALL pulse high for exactly 1 cycle, then the block SHALL return to IDLE.
REQ-026 A vblank that is already high when SWAP is accepted SHALL NOT trigger the swap; the block SHALL wait for the next rising edge.
REQ-027 NOP SHALL be consumed with no effect.
REQ-028 we, wrtPtr, dataIn and swapBuffers SHALL be registered outputs; we and swapBuffers SHALL never both be high.

Reset
REQ-029 Asserting reset SHALL immediately (asynchronously) force state IDLE, we=0, wrtPtr=0, dataIn=0, swapBuffers=0, the registered vblank=0 and all counters=0, including mid-FILL or mid-WAITVBL.
REQ-030 While reset is high, cmdReady SHALL be 0; the first accept SHALL be possible on the first clk edge after deassertion.

Structure
REQ-031 A shared package painter_pkg SHALL hold the opcode constants, the FSM state encoding, and the WIDTH/HEIGHT defaults.
REQ-032 The x/y counters and rowBase address generation SHALL be one sub-module, rect_scanner; the FSM and command latch SHALL stay in rect_painter.

Verification
REQ-033 FILL (2,1)-(4,2) colour 5 -> six writes with wrtPtr 162,163,164,322,323,324 on consecutive cycles, dataIn=5, then we=0.
REQ-034 CLEAR colour 0 -> 19200 consecutive writes with wrtPtr 0..19199 and cmdReady=0 throughout.
REQ-035 FILL (150,118)-(200,127) -> clamped to (150..159, 118..119), giving 20 writes with the last wrtPtr 19199.
REQ-036 FILL x0=10, x1=5 -> no we pulse, and cmdReady is high again the next cycle.
REQ-037 SWAP accepted while vblank is high, vblank falls, then rises 100 cycles later -> a single swapBuffers pulse on the cycle after the rise, none earlier.
REQ-038 reset asserted during the 3rd pixel of a FILL -> we drops to 0 without a clock edge, and after release a new FILL starts cleanly at its own X0/Y0.

Source files
------------

// File: rtl/painter_pkg.sv
// Shared types and constants for the rectangle painter.
// Opcodes, FSM encoding, default frame size and a shift-add helper.
package painter_pkg;

  localparam int DEF_WIDTH  = 160;
  localparam int DEF_HEIGHT = 120;

  typedef enum logic [1:0] {
    OP_FILL  = 2'd0,
    OP_CLEAR = 2'd1,
    OP_SWAP  = 2'd2,
    OP_NOP   = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FILL    = 2'd1,
    S_WAITVBL = 2'd2
  } state_t;

  // y*w as a sum of shifted copies of w, one adder per set bit of y
  function automatic logic [14:0] mulWidth(
    input logic [6:0] y,
    input int         w
  );
    logic [14:0] acc;
    acc = '0;
    for (int i = 0; i < 7; i++) begin
      if (y[i]) acc = acc + 15'(w << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/rect_scanner.sv
// Raster x/y walker for one rectangle.
// Keeps a running row base so each pixel address is a single add.
module rect_scanner
  import painter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic [7:0]  startX,
  input  logic [6:0]  startY,
  input  logic [7:0]  xLo,
  input  logic [7:0]  xHi,
  input  logic [6:0]  yHi,
  output logic [14:0] wrtPtr,
  output logic        last
);

  logic [7:0]  x;
  logic [6:0]  y;
  logic [14:0] rowBase;
  logic [14:0] startBase;
  logic [14:0] nextBase;

  assign startBase = mulWidth(startY, WIDTH);
  assign nextBase  = rowBase + 15'(WIDTH);
  assign last      = (x == xHi) && (y == yHi);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x       <= '0;
      y       <= '0;
      rowBase <= '0;
      wrtPtr  <= '0;
    end else if (load) begin
      x       <= startX;
      y       <= startY;
      rowBase <= startBase;
      wrtPtr  <= startBase + 15'(startX);
    end else if (step) begin
      if (x == xHi) begin
        x       <= xLo;
        y       <= y + 7'd1;
        rowBase <= nextBase;
        wrtPtr  <= nextBase + 15'(xLo);
      end else begin
        x      <= x + 8'd1;
        wrtPtr <= rowBase + 15'(x) + 15'd1;
      end
    end
  end

endmodule

// File: rtl/rect_painter.sv
// Command-driven rectangle filler with vblank-synchronised buffer swap.
// Owns the FSM and command latch; address generation is in rect_scanner.
module rect_painter
  import painter_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmdValid,
  output logic        cmdReady,
  input  logic [1:0]  cmdOp,
  input  logic [7:0]  cmdX0,
  input  logic [7:0]  cmdX1,
  input  logic [6:0]  cmdY0,
  input  logic [6:0]  cmdY1,
  input  logic [2:0]  cmdColor,
  input  logic        vblank,
  output logic        we,
  output logic [14:0] wrtPtr,
  output logic [2:0]  dataIn,
  output logic        swapBuffers,
  output logic        busy
);

  state_t     state;
  op_t        op;
  logic       vblR;
  logic       accept;
  logic       isDraw;
  logic       rectOk;
  logic       load;
  logic       step;
  logic       last;
  logic [7:0] bx0;
  logic [7:0] bx1;
  logic [6:0] by0;
  logic [6:0] by1;
  logic [7:0] xLo;
  logic [7:0] xHi;
  logic [6:0] yHi;

  assign op       = op_t'(cmdOp);
  assign cmdReady = (state == S_IDLE) && !reset;
  assign busy     = ~cmdReady;
  assign accept   = cmdValid && cmdReady;
  assign isDraw   = (op == OP_FILL) || (op == OP_CLEAR);

  // FILL clamps the far corner; CLEAR ignores the given bounds entirely
  always_comb begin
    bx0 = cmdX0;
    by0 = cmdY0;
    bx1 = (cmdX1 > 8'(WIDTH - 1)) ? 8'(WIDTH - 1) : cmdX1;
    by1 = (cmdY1 > 7'(HEIGHT - 1)) ? 7'(HEIGHT - 1) : cmdY1;
    if (op == OP_CLEAR) begin
      bx0 = '0;
      by0 = '0;
      bx1 = 8'(WIDTH - 1);
      by1 = 7'(HEIGHT - 1);
    end
  end

  assign rectOk = (bx0 <= bx1) && (by0 <= by1);
  assign load   = accept && isDraw && rectOk;
  assign step   = (state == S_FILL) && !last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      vblR        <= 1'b0;
      we          <= 1'b0;
      dataIn      <= '0;
      swapBuffers <= 1'b0;
      xLo         <= '0;
      xHi         <= '0;
      yHi         <= '0;
    end else begin
      vblR        <= vblank;
      swapBuffers <= 1'b0;
      unique case (state)
        S_IDLE: begin
          unique case (1'b1)
            load: begin
              state  <= S_FILL;
              we     <= 1'b1;
              dataIn <= cmdColor;
              xLo    <= bx0;
              xHi    <= bx1;
              yHi    <= by1;
            end
            (accept && op == OP_SWAP): state <= S_WAITVBL;
            default: ;
          endcase
        end
        S_FILL: begin
          if (last) begin
            state <= S_IDLE;
            we    <= 1'b0;
          end
        end
        S_WAITVBL: begin
          if (vblank && !vblR) begin
            swapBuffers <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  rect_scanner #(
    .WIDTH(WIDTH)
  ) scanner (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .step   (step),
    .startX (bx0),
    .startY (by0),
    .xLo    (xLo),
    .xHi    (xHi),
    .yHi    (yHi),
    .wrtPtr (wrtPtr),
    .last   (last)
  );

endmodule
